mem_bus_ctrl: RTL and testbench

//  Sequencer between the MIPS core's memory-access stage and the word-wide Ram.

---
 rtl/mem_bus_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-outstanding load/store sequencer between the core's
// memory stage and a word-wide, level-sensitive Ram with a shared tri-state
// data bus and an active-low write strobe.
module mem_bus_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              mem_wre
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_CAPT,
        S_WR_SETUP,
        S_WR_STROBE,
        S_WR_HOLD,
        S_RESP
    } state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_wre;
    logic [DATA_W-1:0]   r_wdata;

    logic [ADDR_W-1:0]   w_word;
    logic                w_err;
    logic                w_accept;

    // Byte address -> word index; anything misaligned or beyond the Ram is an error.
    assign w_word   = req_addr[ADDR_W+1:2];
    assign w_err    = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
    assign w_accept = req_valid && r_req_ready;

    // The bus is only ever driven while the strobe is low, so release and the
    // strobe's rising edge happen on the same clock edge by construction.
    assign mem_data = r_mem_wre ? {DATA_W{1'bz}} : r_wdata;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wre   = r_mem_wre;

    // Store data is latched at accept and held stable until the next accept.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_wdata <= req_wdata;
        end
    end

    // Access sequencer: one transition per edge, all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wre   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_rsp_rdata <= '0;
                        if (w_err) begin
                            // Rejected request: answer immediately, no Ram access.
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_rsp_err  <= 1'b0;
                            r_mem_addr <= w_word;
                            r_state    <= req_we ? S_WR_SETUP : S_RD_ADDR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    r_state <= S_RD_CAPT;
                end
                S_RD_CAPT: begin
                    r_rsp_rdata <= mem_data;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_WR_SETUP: begin
                    r_mem_wre <= 1'b0;
                    r_state   <= S_WR_STROBE;
                end
                S_WR_STROBE: begin
                    r_mem_wre <= 1'b1;
                    r_state   <= S_WR_HOLD;
                end
                S_WR_HOLD: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_mem_wre   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed load/store/error/backpressure/reset scenarios
// against a transaction-level model of the controller plus a Ram model on
// the shared bus.
module tb_mem_bus_ctrl;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    logic              clock     = 1'b0;
    logic              reset     = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_we    = 1'b0;
    logic [31:0]       req_addr  = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_ready = 1'b1;
    wire               req_ready;
    wire               rsp_valid;
    wire  [DATA_W-1:0] rsp_rdata;
    wire               rsp_err;
    wire  [ADDR_W-1:0] mem_addr;
    wire  [DATA_W-1:0] mem_data;
    wire               mem_wre;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mem_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wre   (mem_wre)
    );

    always #5 clock = ~clock;

    // Ram model: drives the bus whenever the strobe is high, writes while low.
    logic [DATA_W-1:0] ram [0:127];
    bit                ram_loaded = 1'b0;
    assign mem_data = mem_wre ? ram[mem_addr] : 32'hzzzz_zzzz;

    always @(negedge clock) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 128; i++) ram[i] <= 32'hA500_0000 | i;
            ram_loaded <= 1'b1;
        end else if (mem_wre == 1'b0) begin
            ram[mem_addr] <= mem_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit f_err(input logic [31:0] a);
        return (a % 32'd4 != 0) || (a >= 32'd512);
    endfunction

    function automatic logic [6:0] f_word(input logic [31:0] a);
        return 7'(a / 32'd4);
    endfunction

    // Transaction-level model: a request is "busy" for a fixed latency
    // (1 error, 3 load, 4 store), then waits for rsp_ready.
    logic [31:0] m_mem [0:127];
    bit          m_loaded = 1'b0;
    bit          m_busy;
    int          m_k;
    int          m_lat;
    bit          m_we;
    bit          m_err;
    logic [6:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            if (!m_loaded) begin
                for (int i = 0; i < 128; i++) m_mem[i] <= 32'hA500_0000 | i;
                m_loaded <= 1'b1;
            end
            m_busy <= 1'b0;
            m_k    <= 0;
            m_lat  <= 1;
            m_we   <= 1'b0;
            m_err  <= 1'b0;
            m_addr <= '0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy  <= 1'b1;
                m_k     <= 1;
                m_we    <= req_we;
                m_err   <= f_err(req_addr);
                m_lat   <= f_err(req_addr) ? 1 : (req_we ? 4 : 3);
                m_wdata <= req_wdata;
                if (!f_err(req_addr)) m_addr <= f_word(req_addr);
                m_rdata <= (f_err(req_addr) || req_we) ? 32'h0 : m_mem[f_word(req_addr)];
            end
        end else if (m_k < m_lat) begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_lat && m_we && !m_err) m_mem[m_addr] <= m_wdata;
        end else if (rsp_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Every-cycle comparison of the DUT against the model and the Ram.
    always @(negedge clock) begin
        if (chk_en) begin
            check("req_ready", req_ready, !m_busy);
            check("rsp_valid", rsp_valid, m_busy && m_k >= m_lat);
            check("mem_wre", mem_wre, !(m_busy && m_we && !m_err && m_k == 2));
            check("mem_addr", mem_addr, m_addr);
            if (m_busy && m_k >= m_lat) begin
                check("rsp_rdata", rsp_rdata, m_rdata);
                check("rsp_err", rsp_err, m_err);
            end
            if (mem_wre === 1'b0) begin
                check("bus_wdata", mem_data, m_wdata);
                check("bus_no_x", $isunknown(mem_data), 0);
            end else begin
                check("bus_released", mem_data, ram[mem_addr]);
            end
        end
    end

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input int bp, output int lat, output logic [31:0] rd,
                          output logic er, output int wlo, output logic [6:0] waddr);
        int n;
        lat = 0; wlo = 0; waddr = '0; rd = '0; er = 1'b0;
        @(negedge clock);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        rsp_ready = (bp == 0);
        @(posedge clock);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clock);
            lat++;
            if (mem_wre === 1'b0) begin
                wlo++;
                waddr = mem_addr;
            end
        end while (rsp_valid !== 1'b1 && lat < 20);
        check("rsp_valid_wait", rsp_valid, 1);
        rd = rsp_rdata;
        er = rsp_err;
        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                // A competing request while the response is stalled must be ignored.
                req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0BAD_0BAD;
                @(negedge clock);
                check("bp_rsp_valid", rsp_valid, 1);
                check("bp_req_ready", req_ready, 0);
                check("bp_rdata_stable", rsp_rdata, rd);
                check("bp_err_stable", rsp_err, er);
                check("bp_no_strobe", mem_wre, 1);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clock);
        #1 rsp_ready = 1'b1;
    endtask

    int          lat, wlo;
    logic [31:0] rd;
    logic        er;
    logic [6:0]  waddr;

    initial begin
        #2 reset = 1'b0;
        #10 chk_en = 1'b1;
        #20;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wre", mem_wre, 1);
        @(negedge clock) reset = 1'b1;

        // Store then load word 4.
        do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, lat, rd, er, wlo, waddr);
        check("st10_lat", lat, 4);
        check("st10_wre_cycles", wlo, 1);
        check("st10_addr", waddr, 7'd4);
        check("st10_err", er, 0);
        check("st10_rdata", rd, 0);
        do_req(1'b0, 32'h0000_0010, 32'h0, 0, lat, rd, er, wlo, waddr);
        check("ld10_lat", lat, 3);
        check("ld10_rdata", rd, 32'hDEAD_BEEF);
        check("ld10_err", er, 0);
        check("ld10_wre_cycles", wlo, 0);

        // Misaligned load and out-of-range store.
        do_req(1'b0, 32'h0000_0006, 32'h0, 0, lat, rd, er, wlo, waddr);
        check("ld06_lat", lat, 1);
        check("ld06_err", er, 1);
        check("ld06_rdata", rd, 0);
        check("ld06_wre_cycles", wlo, 0);
        do_req(1'b1, 32'h0000_0200, 32'h1111_1111, 0, lat, rd, er, wlo, waddr);
        check("st200_lat", lat, 1);
        check("st200_err", er, 1);
        check("st200_rdata", rd, 0);
        check("st200_wre_cycles", wlo, 0);

        // Top word, then read it back under 5 cycles of backpressure.
        do_req(1'b1, 32'h0000_01FC, 32'hCAFE_F00D, 0, lat, rd, er, wlo, waddr);
        check("st1fc_lat", lat, 4);
        check("st1fc_addr", waddr, 7'h7F);
        check("st1fc_wre_cycles", wlo, 1);
        do_req(1'b0, 32'h0000_01FC, 32'h0, 5, lat, rd, er, wlo, waddr);
        check("ld1fc_lat", lat, 3);
        check("ld1fc_rdata", rd, 32'hCAFE_F00D);
        check("ld1fc_err", er, 0);

        // Untouched word keeps its preload; the ignored store to 0x20 never landed.
        do_req(1'b0, 32'h0000_0020, 32'h0, 0, lat, rd, er, wlo, waddr);
        check("ld20_rdata", rd, 32'hA500_0008);

        // Reset in the middle of the write strobe.
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h1234_5678;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        #3;
        check("strobe_wre", mem_wre, 0);
        check("strobe_addr", mem_addr, 7'd16);
        check("strobe_bus", mem_data, 32'h1234_5678);
        reset = 1'b0;
        #1;
        check("arst_wre", mem_wre, 1);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_req_ready", req_ready, 1);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_bus", mem_data, 32'hA500_0000);
        @(negedge clock);
        @(negedge clock) reset = 1'b1;

        // The abandoned store must not have reached the Ram.
        do_req(1'b0, 32'h0000_0040, 32'h0, 0, lat, rd, er, wlo, waddr);
        check("ld40_lat", lat, 3);
        check("ld40_rdata", rd, 32'hA500_0010);

        repeat (3) @(negedge clock);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
